ppu_timing: RTL
===============

Name: ppu_timing

Overview:
- Dot/scanline timing generator for the PPU, clocked by the PPU dot clock (the divided PPU clock output of the clock divider).
- Produces the 341-dot x 262-line NTSC raster position, visible-area qualifiers and frame pulses.
- Produces the VBlank status flag and the active-low NMI request to the CPU.
- Implements the odd-frame dot skip and the $2002 read-clear / suppression rules.

Parameters:
DOTS_PER_LINE, 341, dots per scanline (Dot counts 0..DOTS_PER_LINE-1)
LINES_PER_FRAME, 262, scanlines per frame (Scanline counts 0..LINES_PER_FRAME-1)
VISIBLE_LINES, 240, visible scanlines 0..VISIBLE_LINES-1
VBLANK_LINE, 241, scanline on which VBlank is set
VISIBLE_DOTS, 256, visible dots 1..VISIBLE_DOTS

Ports:
Clk  in  1  PPU dot clock; all state advances on rising edge
Reset  in  1  asynchronous, active-high reset
RenderEn  in  1  background or sprite rendering enabled (PPUMASK bits 3|4)
NmiEnable  in  1  PPUCTRL bit 7
StatusRead  in  1  one-Clk pulse: CPU read of $2002 this cycle
Dot  out  9  current dot, 0..340
Scanline  out  9  current scanline, 0..261 (261 = pre-render)
PixelX  out  8  Dot-1 when Visible, else 0
PixelY  out  8  Scanline[7:0] when Scanline<240, else 0
Visible  out  1  Scanline<240 && 1<=Dot<=256
VBlank  out  1  VBlank status flag ($2002 bit 7)
Nmi_n  out  1  active-low NMI request
FrameStart  out  1  high for exactly the cycle counters read (0,0)
OddFrame  out  1  parity of the current frame

Behaviour:
- Reset (async, active-high):
  - Dot=0, Scanline=0, VBlank=0, OddFrame=0, Nmi_n=1.
  - Combinational outputs follow from these values (FrameStart=1 while held in reset at (0,0), Visible=0).
  - Reset mid-frame aborts immediately; counting resumes from (0,0) on the first rising edge after release.
- Counting, one step per rising Clk edge:
  - Dot increments.
  - At Dot=340, Dot goes to 0 and Scanline increments.
  - At (261,340), next is (0,0).
- Odd-frame skip:
  - If counters read (261,339), OddFrame=1 and RenderEn=1 (sampled that cycle), next is (0,0) and dot 340 is skipped.
  - Otherwise normal count.
- OddFrame toggles on every transition into (0,0), whether normal wrap or skip.
- Frame length:
  - 89342 cycles normally.
  - 89341 when the skip occurs.
- VBlank flag (registered; semantics coincident with counter outputs):
  - Set: becomes 1 in the cycle counters read (241,1).
  - Set suppression: if StatusRead=1 while counters read (241,0), the set is suppressed for the whole frame and VBlank stays 0.
  - Clear on pre-render: becomes 0 in the cycle counters read (261,1).
  - Clear on read: StatusRead=1 in any other cycle makes VBlank 0 from the next cycle.
  - Simultaneous StatusRead with the (261,1) clear: result 0.
  - Priority: clear > set.
- Nmi_n = ~(VBlank & NmiEnable), combinational from the registered VBlank.
  - NmiEnable rising while VBlank=1 drops Nmi_n in the same cycle, producing a new NMI edge.
  - NmiEnable falling raises Nmi_n.
- Visible, PixelX, PixelY and FrameStart are pure decodes of the current Dot/Scanline; they add no extra latency.
- Unreachable counter values (Dot>340 or Scanline>261) are forced to (0,0) on the next edge.

Test Plan:
- Release Reset, free-run -> FrameStart=1 at cycle 0; Scanline=1, Dot=0 after 341 cycles; Visible=1 first at (0,1) with PixelX=0; PixelX=255 at (0,256); Visible=0 at (0,257).
- NmiEnable=1, free-run -> VBlank=1 and Nmi_n=0 at cycle 82182 from (0,0), i.e. (241,1); both return (VBlank=0, Nmi_n=1) at cycle 89002, i.e. (261,1).
- RenderEn=1 for two frames -> frame 0 (OddFrame=0) lasts 89342 cycles; frame 1 (OddFrame=1) lasts 89341 cycles, with (261,339)->(0,0). Repeat with RenderEn=0 -> both frames last 89342.
- StatusRead pulse at (250,100) with NmiEnable=1 -> VBlank=0 and Nmi_n=1 from (250,101); both stay deasserted until next frame's (241,1).
- StatusRead pulse at (241,0) -> VBlank stays 0 and Nmi_n stays 1 for the entire frame; the next frame sets normally.
- During VBlank, NmiEnable 0->1 -> Nmi_n falls in the same cycle. Then assert Reset at (250,5) -> immediately Dot=0, Scanline=0, VBlank=0, OddFrame=0, Nmi_n=1.

Source files
------------

// File: rtl/ppu_timing.sv
// ppu_timing: NTSC dot/scanline raster generator for the PPU.
// Produces the raster position, the visible-area decodes, the frame start
// pulse, the VBlank status flag and the active-low NMI request. It also
// implements the odd-frame dot skip and the $2002 read-clear and suppression
// behaviour.
module ppu_timing #(
  parameter int unsigned DOTS_PER_LINE   = 341,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned VISIBLE_LINES   = 240,
  parameter int unsigned VBLANK_LINE     = 241,
  parameter int unsigned VISIBLE_DOTS    = 256
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RenderEn,
  input  logic       NmiEnable,
  input  logic       StatusRead,
  output logic [8:0] Dot,
  output logic [8:0] Scanline,
  output logic [7:0] PixelX,
  output logic [7:0] PixelY,
  output logic       Visible,
  output logic       VBlank,
  output logic       Nmi_n,
  output logic       FrameStart,
  output logic       OddFrame
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] PRE_LINE  = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
  localparam logic [8:0] VIS_DOTS  = 9'(VISIBLE_DOTS);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       vblank_q, vblank_d;
  logic       visible_s;

  // Next raster position: normal advance, end-of-line wrap, end-of-frame wrap
  // (including the odd-frame skip of the final pre-render dot).
  always_comb begin
    dot_d  = dot_q + 9'd1;
    line_d = line_q;
    odd_d  = odd_q;
    if ((dot_q > LAST_DOT) || (line_q > PRE_LINE)) begin
      // Out-of-range counters recover to the frame origin.
      dot_d  = 9'd0;
      line_d = 9'd0;
    end else if ((line_q == PRE_LINE) &&
                 ((dot_q == LAST_DOT) ||
                  ((dot_q == SKIP_DOT) && odd_q && RenderEn))) begin
      // Every entry into (0,0) starts a new frame and flips its parity.
      dot_d  = 9'd0;
      line_d = 9'd0;
      odd_d  = ~odd_q;
    end else if (dot_q == LAST_DOT) begin
      dot_d  = 9'd0;
      line_d = line_q + 9'd1;
    end else begin
      dot_d  = dot_q + 9'd1;
    end
  end

  // Next VBlank flag. The pre-render clear wins over everything; a status
  // read clears it, and a read one dot before the set point also swallows
  // that frame's only set opportunity.
  always_comb begin
    vblank_d = vblank_q;
    if ((line_q == PRE_LINE) && (dot_q == 9'd0)) begin
      vblank_d = 1'b0;
    end else if (StatusRead) begin
      vblank_d = 1'b0;
    end else if ((line_q == VBL_LINE) && (dot_q == 9'd0)) begin
      vblank_d = 1'b1;
    end else begin
      vblank_d = vblank_q;
    end
  end

  // Raster, frame parity and VBlank state registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dot_q    <= 9'd0;
      line_q   <= 9'd0;
      odd_q    <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      odd_q    <= odd_d;
      vblank_q <= vblank_d;
    end
  end

  // Position decodes are combinational so they line up with Dot/Scanline.
  assign visible_s  = (line_q < VIS_LINES) && (dot_q >= 9'd1) && (dot_q <= VIS_DOTS);

  assign Dot        = dot_q;
  assign Scanline   = line_q;
  assign Visible    = visible_s;
  assign PixelX     = visible_s ? 8'(dot_q - 9'd1) : 8'd0;
  assign PixelY     = (line_q < VIS_LINES) ? line_q[7:0] : 8'd0;
  assign FrameStart = (dot_q == 9'd0) && (line_q == 9'd0);
  assign OddFrame   = odd_q;
  assign VBlank     = vblank_q;
  // NmiEnable acts immediately so enabling it during VBlank makes a new edge.
  assign Nmi_n      = ~(vblank_q & NmiEnable);

endmodule
